switch_debouncer: RTL
=====================

// Module: switch_debouncer
//
// PURPOSE
//   Conditions the raw board slide-switches before they reach the system's
//   switches[3:0] input. Each bit is synchronised into the clock domain and
//   debounced: a new level is accepted only after it has been stable for
//   DEBOUNCE_CYCLES consecutive clocks. Sits between the board pins and system.
//
// PARAMETERS
//   WIDTH           4          number of switch bits
//   DEBOUNCE_CYCLES 1_000_000  clocks a level must hold (10 ms at 100 MHz); >= 1
//   SYNC_STAGES     2          synchroniser flops per bit; >= 2
//
// PORTS
//   clock        in   1      system clock, 100 MHz, rising edge
//   reset        in   1      asynchronous, active-low (asserted at 0)
//   switches_raw in   WIDTH  unsynchronised switch pins
//   switches     out  WIDTH  debounced level, feeds system.switches
//   changed      out  1      one-cycle pulse when any bit of switches updates
//   rise         out  WIDTH  [SWITCH_EDGE_EN only] per-bit 0->1 pulse
//   fall         out  WIDTH  [SWITCH_EDGE_EN only] per-bit 1->0 pulse
//
// BEHAVIOUR
//   - Reset (reset==0): sync flops, counters, switches, changed, rise, fall all
//     0 immediately; these values hold until the first edge after release.
//   - Sync: switches_raw[i] passes through SYNC_STAGES flops -> synced[i].
//   - Per bit, counter cnt of width $clog2(DEBOUNCE_CYCLES+1), saturating:
//       synced == switches : cnt <= 0
//       synced != switches, cnt <  D-1 : cnt <= cnt+1
//       synced != switches, cnt == D-1 : switches <= synced, cnt <= 0
//   - Latency: a raw step held steady appears on switches exactly
//     SYNC_STAGES + DEBOUNCE_CYCLES rising edges after the first edge that
//     samples it (D=4, 2 stages -> 6 edges).
//   - Glitch: any return of synced to the accepted level before D consecutive
//     differing cycles clears cnt; switches never changes.
//   - Bits are independent; several bits may update on the same edge.
//   - changed = 1 for exactly the cycle after an edge on which >= 1 bit of
//     switches updated; registered, no combinational path from switches_raw.
//   - Reset mid-count discards progress; after release counting restarts at 0
//     against switches == 0 (a held-high switch reappears after full latency).
//
// CONFIGURATION
//   SWITCH_EDGE_EN defined : rise/fall ports exist; rise[i] (fall[i]) is a
//     one-cycle registered pulse coincident with changed when bit i goes
//     0->1 (1->0).
//   SWITCH_EDGE_EN undefined: rise/fall ports and logic absent; all other
//     behaviour identical.
//
// STRUCTURE
//   - scic_pkg: SCIC_SWITCH_WIDTH (4), SCIC_CLK_HZ (100_000_000),
//     SCIC_DEBOUNCE_MS (10) for the top-level instantiation.
//   - Sub-module debounce_bit: one synchroniser + counter + accepted level;
//     generated WIDTH times. Top level ORs update strobes into changed and
//     forms rise/fall.
//
// TESTING  (bench uses DEBOUNCE_CYCLES=4, SYNC_STAGES=2, 10 ns clock)
//   1 Reset held 0, raw=4'b1111 -> switches=0, changed=0 during reset and for
//     6 edges after release; switches=4'b1111 on edge 6, changed=1 one cycle.
//   2 raw[0] 0->1 held -> switches[0]=1 exactly 6 edges later; changed
//     pulses once; with SWITCH_EDGE_EN rise=4'b0001, fall=0 that cycle.
//   3 raw[1] toggles 1,0,1,0 each 3 clocks for 24 clocks -> switches[1]
//     stays 0, changed never asserts.
//   4 raw 4'b0011->4'b1100 in one edge -> switches updates all 4 bits on the
//     same edge; changed one cycle; rise=4'b1100, fall=4'b0011.
//   5 raw[2] high 4 clocks (count reaches 2), reset pulsed low async
//     mid-cycle -> switches=0 at once; after release raw[2] still high ->
//     switches[2]=1 6 edges after release.
//   6 Hold raw constant 100 clocks after settling -> switches constant,
//     changed/rise/fall remain 0.

Source files
------------

// File: rtl/scic_pkg.sv
// Shared constants for the switch conditioning path: switch count, clock rate
// and debounce window, plus the debounce counter width helper.
package scic_pkg;

    localparam int unsigned SCIC_SWITCH_WIDTH    = 4;
    localparam int unsigned SCIC_CLK_HZ          = 100_000_000;
    localparam int unsigned SCIC_DEBOUNCE_MS     = 10;
    localparam int unsigned SCIC_SYNC_STAGES     = 2;
    localparam int unsigned SCIC_DEBOUNCE_CYCLES = (SCIC_CLK_HZ / 1000) * SCIC_DEBOUNCE_MS;

    // Counter must hold values 0..cycles, which also covers cycles == 1.
    function automatic int unsigned scic_cnt_width(input int unsigned cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: SyncStages-deep synchroniser, saturating stability counter and
// the accepted level. update_o strobes on the cycle before the level flips.
module debounce_bit
    import scic_pkg::*;
#(
    parameter int unsigned DebounceCycles = 4,
    parameter int unsigned SyncStages     = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_i,
    output logic level_o,
    output logic update_o
);

    localparam int unsigned CntW = scic_cnt_width(DebounceCycles);
    localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

    logic [SyncStages-1:0] sync_q;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  level_q, level_d;
    logic                  synced;
    logic                  update;

    assign synced = sync_q[SyncStages-1];

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        update  = 1'b0;
        if (synced == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            // This edge is the DebounceCycles-th consecutive differing cycle.
            update  = 1'b1;
            level_d = synced;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SyncStages-2:0], raw_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o  = level_q;
    assign update_o = update;

endmodule

// File: rtl/switch_debouncer.sv
// Synchronises and debounces WIDTH raw slide switches; changed pulses after any update.
// Define SWITCH_EDGE_EN to add per-bit registered rise/fall pulses.
module switch_debouncer
    import scic_pkg::*;
#(
    parameter int unsigned WIDTH           = SCIC_SWITCH_WIDTH,
    parameter int unsigned DEBOUNCE_CYCLES = SCIC_DEBOUNCE_CYCLES,
    parameter int unsigned SYNC_STAGES     = SCIC_SYNC_STAGES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] switches_raw,
    output logic [WIDTH-1:0] switches,
    output logic             changed
`ifdef SWITCH_EDGE_EN
    ,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
`endif
);

    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] update;
    logic             changed_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DebounceCycles(DEBOUNCE_CYCLES),
            .SyncStages    (SYNC_STAGES)
        ) u_bit (
            .clock   (clock),
            .reset   (reset),
            .raw_i   (switches_raw[i]),
            .level_o (level[i]),
            .update_o(update[i])
        );
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= |update;
        end
    end

    assign switches = level;
    assign changed  = changed_q;

`ifdef SWITCH_EDGE_EN
    logic [WIDTH-1:0] rise_q, fall_q;

    // A bit only updates when it differs, so the new value is ~level.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= update & ~level;
            fall_q <= update & level;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`endif

endmodule
